// File: rtl/crc_buffer_compare_if.sv
// Bus between the CRC fingerprint comparator and its controller / buffer pair.
// slave is the comparator side; master is the controller plus buffer side.
interface crc_buffer_compare_if #(
  parameter int cw = 32,
  parameter int rw = 4
);
  logic          start;
  logic [rw-1:0] base_addr;
  logic [rw:0]   count;
  logic          stop_on_mismatch;
  logic [rw-1:0] addr_r;
  logic [cw-1:0] data_a;
  logic [cw-1:0] data_b;
  logic          busy;
  logic          done;
  logic          mismatch;
  logic [rw-1:0] mismatch_addr;
  logic [rw:0]   match_count;

  modport slave (
    input  start, base_addr, count, stop_on_mismatch, data_a, data_b,
    output addr_r, busy, done, mismatch, mismatch_addr, match_count
  );

  modport master (
    output start, base_addr, count, stop_on_mismatch, data_a, data_b,
    input  addr_r, busy, done, mismatch, mismatch_addr, match_count
  );
endinterface

// File: rtl/crc_buffer_compare.sv
// Walks a range of two CRC fingerprint buffers through one shared read address and
// compares them entry by entry, reporting first divergence and number of matches.
module crc_buffer_compare #(
  parameter int cw = 32,
  parameter int rw = 4,
  parameter int rs = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  crc_buffer_compare_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [rw-1:0] addr_q, addr_d;
  logic [rw:0]   remain_q, remain_d;
  logic          stop_q, stop_d;
  logic          v1_q, v1_d;
  logic [rw-1:0] tag_q, tag_d;
  logic          done_q, done_d;
  logic          mm_q, mm_d;
  logic [rw-1:0] mma_q, mma_d;
  logic [rw:0]   mc_q, mc_d;

  logic [cw-1:0] diff;
  logic          cmp_eq;
  logic          start_ok;
  logic          last_issue;
  logic          early_stop;

  // v1_q tags the buffer data currently on data_a/data_b (address issued last cycle).
  assign diff       = bus.data_a ^ bus.data_b;
  assign cmp_eq     = ~|diff;
  assign start_ok   = (state_q == IDLE) && bus.start;
  assign last_issue = (remain_q == (rw+1)'(1));
  assign early_stop = v1_q && !cmp_eq && stop_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      stop_q   <= 1'b0;
      v1_q     <= 1'b0;
      tag_q    <= '0;
      done_q   <= 1'b0;
      mm_q     <= 1'b0;
      mma_q    <= '0;
      mc_q     <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      stop_q   <= stop_d;
      v1_q     <= v1_d;
      tag_q    <= tag_d;
      done_q   <= done_d;
      mm_q     <= mm_d;
      mma_q    <= mma_d;
      mc_q     <= mc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start && (bus.count != '0)) state_d = READ;
      READ:    if (early_stop) state_d = IDLE;
               else if (last_issue) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    remain_d = remain_q;
    stop_d   = stop_q;
    v1_d     = 1'b0;
    tag_d    = tag_q;
    done_d   = 1'b0;
    mm_d     = mm_q;
    mma_d    = mma_q;
    mc_d     = mc_q;

    if (start_ok) begin
      addr_d   = bus.base_addr;
      remain_d = bus.count;
      stop_d   = bus.stop_on_mismatch;
      mm_d     = 1'b0;
      mma_d    = '0;
      mc_d     = '0;
      done_d   = (bus.count == '0);
    end

    // An early stop squashes the read issued this cycle along with the FSM.
    if ((state_q == READ) && !early_stop) begin
      v1_d     = 1'b1;
      tag_d    = addr_q;
      remain_d = remain_q - 1'b1;
      if (!last_issue) addr_d = (addr_q == rw'(rs - 1)) ? '0 : addr_q + 1'b1;
    end

    if (v1_q) begin
      if (cmp_eq) begin
        mc_d = mc_q + 1'b1;
      end else if (!mm_q) begin
        mm_d  = 1'b1;
        mma_d = tag_q;
      end
    end

    // DRAIN only ever holds the final in-flight compare, so it always lasts one cycle.
    if ((state_q == DRAIN) || early_stop) done_d = 1'b1;
  end

  assign bus.addr_r        = addr_q;
  assign bus.busy          = (state_q != IDLE);
  assign bus.done          = done_q;
  assign bus.mismatch      = mm_q;
  assign bus.mismatch_addr = mma_q;
  assign bus.match_count   = mc_q;
endmodule

// File: tb/tb_crc_buffer_compare.sv
// Scoreboard bench for crc_buffer_compare: a reference walk over two modelled
// buffers predicts each run; a done monitor pops and compares the prediction.
module tb_crc_buffer_compare;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  logic [31:0] mem_a [16];
  logic [31:0] mem_b [16];
  logic [3:0]  rd_addr = '0;

  typedef struct {
    int         sc;
    int         dc;
    int         base;
    int         cnt;
    logic       mm;
    logic [3:0] mma;
    logic [4:0] mc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  crc_buffer_compare_if #(.cw(32), .rw(4)) bus ();

  crc_buffer_compare #(.cw(32), .rw(4), .rs(16)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffers register the read address and return data combinationally.
  always @(posedge clk) rd_addr <= bus.addr_r;
  assign bus.data_a = mem_a[rd_addr];
  assign bus.data_b = mem_b[rd_addr];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int base, input int cnt, input bit stop);
    exp_t e;
    int   a;
    e.sc = 0; e.base = base; e.cnt = cnt;
    e.mm = 1'b0; e.mma = '0; e.mc = '0;
    e.dc = (cnt == 0) ? 1 : cnt + 2;
    for (int k = 0; k < cnt; k++) begin
      a = (base + k) % 16;
      if (mem_a[a] == mem_b[a]) begin
        e.mc = e.mc + 1'b1;
      end else begin
        if (!e.mm) begin
          e.mm  = 1'b1;
          e.mma = a[3:0];
        end
        if (stop) begin
          e.dc = k + 3;
          break;
        end
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        chk("done_cycle", 64'(cyc - mon_e.sc), 64'(mon_e.dc));
        chk("busy_at_done", bus.busy, 0);
        chk("mismatch", bus.mismatch, mon_e.mm);
        chk("mismatch_addr", bus.mismatch_addr, mon_e.mma);
        chk("match_count", bus.match_count, mon_e.mc);
        $display("run base=%0d count=%0d: done@%0d mismatch=%0d addr=%0d matches=%0d",
                 mon_e.base, mon_e.cnt, cyc - mon_e.sc, bus.mismatch,
                 bus.mismatch_addr, bus.match_count);
      end
    end
  end

  task automatic sync_mem();
    for (int i = 0; i < 16; i++) begin
      mem_a[i] = $urandom;
      mem_b[i] = mem_a[i];
    end
  endtask

  task automatic run(input int base, input int cnt, input bit stop, input int poke, input int rst_at);
    exp_t e;
    int   rel;
    int   last_addr;
    bit   fin;
    e = model(base, cnt, stop);
    last_addr = (cnt < e.dc - 2) ? cnt : e.dc - 2;
    @(posedge clk); #1;
    bus.base_addr = base[3:0];
    bus.count = cnt[4:0];
    bus.stop_on_mismatch = stop;
    bus.start = 1'b1;
    e.sc = cyc;
    sb.push_back(e);
    fin = 1'b0;
    for (int i = 0; i < 100 && !fin; i++) begin
      @(posedge clk); #1;
      rel = cyc - e.sc;
      bus.start = (poke != 0) && (rel == poke);
      if (bus.start) begin
        bus.base_addr = 4'd9;
        bus.count = 5'd3;
      end
      if ((rst_at != 0) && (rel == rst_at)) reset_n = 1'b0;
      @(negedge clk);
      if ((rst_at != 0) && (rel == rst_at + 1)) begin
        chk("rst_addr_r", bus.addr_r, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_mismatch", bus.mismatch, 0);
        chk("rst_mismatch_addr", bus.mismatch_addr, 0);
        chk("rst_match_count", bus.match_count, 0);
        sb.delete();
        fin = 1'b1;
      end else begin
        if (rel >= 1 && rel <= last_addr) chk("addr_r", bus.addr_r, 64'((base + rel - 1) % 16));
        if (rel < e.dc) chk("busy", bus.busy, (cnt != 0));
        #1;
        if (sb.size() == 0) fin = 1'b1;
      end
    end
    if (!fin) begin
      chk("timeout", 1, 0);
      sb.delete();
    end
  endtask

  initial begin
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.count = '0;
    bus.stop_on_mismatch = 1'b0;
    sync_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_addr_r", bus.addr_r, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_mismatch", bus.mismatch, 0);
    chk("reset_match_count", bus.match_count, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    run(0, 16, 1'b0, 0, 0);
    mem_b[5] = mem_a[5] ^ 32'h1;
    run(0, 8, 1'b0, 0, 0);
    sync_mem();
    mem_b[0] = ~mem_a[0];
    run(14, 4, 1'b1, 0, 0);
    sync_mem();
    mem_b[3] = mem_a[3] ^ 32'h8000_0000;
    mem_b[9] = mem_a[9] ^ 32'h0001_0000;
    run(0, 12, 1'b0, 0, 0);
    run(0, 0, 1'b0, 0, 0);
    mem_b[10] = mem_a[10] + 32'd1;
    mem_b[2]  = mem_a[2] - 32'd1;
    run(7, 20, 1'b0, 0, 0);
    run(0, 8, 1'b0, 4, 0);
    run(0, 8, 1'b0, 0, 5);

    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (15) begin
      @(negedge clk);
      chk("no_done_after_reset", bus.done, 0);
    end
    run(3, 2, 1'b1, 0, 0);
    chk("scoreboard_empty", 64'(sb.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
